// File: rtl/perf_event_monitor.sv
// Pipeline performance monitor: free-running cycle counter plus NUM_EVT event counters with shadow readout.
// Optional macro PERF_EVENT_MONITOR_WRAP_EN: counters wrap to 0 (sticky overflow flag) instead of saturating.
//
// state | meaning
// IDLE  | not counting, waiting for start_i
// RUN   | counting cycles and event strobes
// DONE  | cycle limit reached, counts frozen until clr_i or reset
module perf_event_monitor #(
  parameter int NUM_EVT     = 4,
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 30,
  parameter int SEL_W       = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               clr_i,
  input  logic               snap_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic [CNT_W-1:0]   cycle_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [NUM_EVT:0]   sat_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(CYCLE_LIMIT);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q    [NUM_EVT+1];
  logic [CNT_W-1:0]   cnt_d    [NUM_EVT+1];
  logic [CNT_W-1:0]   shadow_q [NUM_EVT+1];
  logic [NUM_EVT:0]   sat_q, sat_d, ovf, inc;
  logic               en, hit;

  assign en  = start_i & (state_q != DONE) & ~clr_i;
  // Index NUM_EVT is the cycle counter; it increments on every enabled edge.
  assign inc = {en, evt_i & {NUM_EVT{en}}};

  always_comb begin
    for (int k = 0; k <= NUM_EVT; k++) begin
      cnt_d[k] = cnt_q[k];
      ovf[k]   = 1'b0;
      if (inc[k]) begin
        if (cnt_q[k] == '1) begin
          ovf[k] = 1'b1;
`ifdef PERF_EVENT_MONITOR_WRAP_EN
          cnt_d[k] = '0;
`else
          cnt_d[k] = cnt_q[k];
`endif
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
      end
    end
    sat_d = sat_q | ovf;
  end

  assign hit = (LIMIT != '0) & inc[NUM_EVT] & (cnt_d[NUM_EVT] == LIMIT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_i) state_d = hit ? DONE : RUN;
      RUN: begin
        if (!start_i)  state_d = IDLE;
        else if (hit)  state_d = DONE;
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (clr_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      sat_q   <= '0;
      for (int k = 0; k <= NUM_EVT; k++) begin
        cnt_q[k]    <= '0;
        shadow_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      sat_q   <= clr_i ? '0 : sat_d;
      for (int k = 0; k <= NUM_EVT; k++) begin
        cnt_q[k] <= clr_i ? '0 : cnt_d[k];
        // Auto-snapshot captures the terminating cycle's increments.
        if (hit)         shadow_q[k] <= cnt_d[k];
        else if (snap_i) shadow_q[k] <= cnt_q[k];
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k <= NUM_EVT; k++)
      if (rd_sel_i == SEL_W'(k)) rd_data_o = shadow_q[k];
  end

  assign cycle_o = cnt_q[NUM_EVT];
  assign busy_o  = (state_q == RUN);
  assign done_o  = (state_q == DONE);
  assign sat_o   = sat_q;

endmodule

// File: tb/tb_perf_event_monitor.sv
// Directed, table-driven bench for perf_event_monitor (32-bit limited instance and 8-bit unlimited instance).
module tb_perf_event_monitor;

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] exp;
  } rd_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_start = 0, a_clr = 0, a_snap = 0;
  logic [3:0]  a_evt = '0;
  logic [4:0]  a_sel = '0;
  logic [31:0] a_rd, a_cyc;
  logic        a_busy, a_done;
  logic [4:0]  a_sat;

  logic        b_start = 0, b_clr = 0, b_snap = 0;
  logic [3:0]  b_evt = '0;
  logic [4:0]  b_sel = '0;
  logic [7:0]  b_rd, b_cyc;
  logic        b_busy, b_done;
  logic [4:0]  b_sat;

  int errors = 0;
  int checks = 0;

  rd_vec_t tbl_done [8];
  rd_vec_t tbl_pause[3];
  rd_vec_t tbl_snclr[3];
  rd_vec_t tbl_rst  [3];

`ifdef PERF_EVENT_MONITOR_WRAP_EN
  localparam logic [7:0] B_EXP = 8'd44;
`else
  localparam logic [7:0] B_EXP = 8'd255;
`endif

  perf_event_monitor #(.NUM_EVT(4), .CNT_W(32), .CYCLE_LIMIT(30), .SEL_W(5)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(a_start), .evt_i(a_evt), .clr_i(a_clr),
    .snap_i(a_snap), .rd_sel_i(a_sel), .rd_data_o(a_rd), .cycle_o(a_cyc),
    .busy_o(a_busy), .done_o(a_done), .sat_o(a_sat));

  perf_event_monitor #(.NUM_EVT(4), .CNT_W(8), .CYCLE_LIMIT(0), .SEL_W(5)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(b_start), .evt_i(b_evt), .clr_i(b_clr),
    .snap_i(b_snap), .rd_sel_i(b_sel), .rd_data_o(b_rd), .cycle_o(b_cyc),
    .busy_o(b_busy), .done_o(b_done), .sat_o(b_sat));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_tbl(input string name, input rd_vec_t t[]);
    for (int i = 0; i < t.size(); i++) begin
      a_sel = t[i].sel;
      #1;
      chk($sformatf("%s sel=%0d", name, t[i].sel), a_rd, t[i].exp);
    end
  endtask

  initial begin
    tbl_done = '{'{5'd0, 32'd30}, '{5'd1, 32'd0}, '{5'd2, 32'd0}, '{5'd3, 32'd0},
                 '{5'd4, 32'd30}, '{5'd5, 32'd0}, '{5'd6, 32'd0}, '{5'd7, 32'd0}};
    tbl_pause = '{'{5'd1, 32'd9}, '{5'd4, 32'd9}, '{5'd0, 32'd0}};
    tbl_snclr = '{'{5'd0, 32'd12}, '{5'd4, 32'd12}, '{5'd1, 32'd0}};
    tbl_rst   = '{'{5'd0, 32'd3}, '{5'd2, 32'd3}, '{5'd1, 32'd0}};

    // reset state
    #12;
    chk("reset cycle", a_cyc, 0);
    chk("reset busy", a_busy, 0);
    chk("reset done", a_done, 0);
    chk("reset sat", a_sat, 0);
    rst = 1'b1;
    step(1);

    // run to the cycle limit
    a_start = 1; a_evt = 4'b0001;
    step(29);
    chk("pre-limit busy", a_busy, 1);
    chk("pre-limit done", a_done, 0);
    step(1);
    chk("limit done", a_done, 1);
    chk("limit busy", a_busy, 0);
    chk("limit cycle", a_cyc, 30);
    run_tbl("done rd", tbl_done);
    step(10);
    chk("frozen cycle", a_cyc, 30);
    chk("frozen done", a_done, 1);
    a_sel = 0; #1;
    chk("frozen evt0", a_rd, 30);
    chk("no sat", a_sat, 0);

    // clear keeps shadows; pause/resume
    a_start = 0; a_clr = 1;
    step(1);
    a_clr = 0;
    chk("clr cycle", a_cyc, 0);
    chk("clr done", a_done, 0);
    a_sel = 0; #1;
    chk("clr keeps shadow", a_rd, 30);
    a_evt = 4'b0010; a_start = 1;
    step(5);
    chk("run busy", a_busy, 1);
    a_start = 0;
    step(3);
    chk("pause busy", a_busy, 0);
    chk("pause cycle", a_cyc, 5);
    a_start = 1;
    step(4);
    a_start = 0; a_snap = 1;
    step(1);
    a_snap = 0;
    chk("resume cycle", a_cyc, 9);
    run_tbl("pause rd", tbl_pause);

    // snap and clr on the same edge
    a_clr = 1; step(1); a_clr = 0;
    a_evt = 4'b0001; a_start = 1;
    step(12);
    chk("pre snapclr cycle", a_cyc, 12);
    a_start = 0; a_snap = 1; a_clr = 1;
    step(1);
    a_snap = 0; a_clr = 0;
    chk("snapclr cycle", a_cyc, 0);
    chk("snapclr sat", a_sat, 0);
    chk("snapclr busy", a_busy, 0);
    chk("snapclr done", a_done, 0);
    run_tbl("snapclr rd", tbl_snclr);

    // asynchronous reset mid-run
    a_evt = 4'b0101; a_start = 1;
    step(7);
    chk("pre-reset cycle", a_cyc, 7);
    chk("pre-reset busy", a_busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("async cycle", a_cyc, 0);
    chk("async busy", a_busy, 0);
    chk("async done", a_done, 0);
    chk("async sat", a_sat, 0);
    a_sel = 0; #0;
    chk("async rd", a_rd, 0);
    #1 rst = 1'b1;
    step(3);
    chk("restart cycle", a_cyc, 3);
    a_start = 0;
    step(1);
    a_snap = 1;
    step(1);
    a_snap = 0;
    run_tbl("restart rd", tbl_rst);

    // 8-bit counters, unlimited run
    b_evt = 4'b0100; b_start = 1;
    step(300);
    b_start = 0; b_snap = 1;
    step(1);
    b_snap = 0;
    b_sel = 2; #1;
    chk("b evt2", b_rd, B_EXP);
    b_sel = 4; #1;
    chk("b cyc shadow", b_rd, B_EXP);
    b_sel = 0; #1;
    chk("b evt0", b_rd, 0);
    chk("b sat", b_sat, 5'b10100);
    chk("b cycle", b_cyc, B_EXP);
    chk("b done", b_done, 0);
    chk("b busy", b_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
